// File: rtl/mux8_rr_sel_if.sv
// Handshake bundle between the round-robin select controller and its
// requesters/consumer behind the 8:1 Mux8 datapath stage.
//   req        requester -> controller  per-channel level request
//   out_ready  consumer  -> controller  current transfer accepted
//   out_valid  controller -> consumer   sel/grant valid
//   sel        controller -> Mux8       binary channel index
//   grant      controller -> consumer   one-hot of sel while valid, else 0
//   out_last   controller -> consumer   current transfer ends the burst
// master: requester/consumer side; slave: the controller.
interface mux8_rr_sel_if;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       out_last;

  modport master (
    output req,
    output out_ready,
    input  out_valid,
    input  sel,
    input  grant,
    input  out_last
  );

  modport slave (
    input  req,
    input  out_ready,
    output out_valid,
    output sel,
    output grant,
    output out_last
  );
endinterface

// File: rtl/mux8_rr_sel.sv
// Round-robin select controller for the 8:1 Mux8 datapath stage.
// Arbitrates eight level-sensitive request lines and grants one channel for a
// burst of at most MAX_BURST transfers, then rotates priority past it.
// Ports:
//   clk  single clock, all state on posedge
//   rst  asynchronous active-high reset
//   bus  mux8_rr_sel_if.slave: req/out_ready in; out_valid/sel/grant/out_last out
// Parameters:
//   MAX_BURST  transfers per grant before forced rotation (1..255)
//   CNT_W      burst counter width, must hold MAX_BURST-1
module mux8_rr_sel #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux8_rr_sel_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic             valid_r;
  logic [2:0]       sel_r;
  logic [7:0]       grant_r;
  logic [2:0]       ptr_r;
  logic [CNT_W-1:0] cnt_r;

  logic [2:0]       arb_start_s;
  logic [3:0]       pick_s;

  // First set request bit scanning start, start+1, ... wrapping 7->0.
  // Returns {found, index}. Scanning from the far end lets the nearest hit win.
  function automatic logic [3:0] rr_pick(input logic [7:0] req_v, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (req_v[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration start: in BUSY a release rotates to sel+1, so the search is
  // done from there on the same edge (no bubble between bursts).
  always_comb begin
    arb_start_s = ptr_r;
    if (state_r == ST_BUSY) begin
      arb_start_s = sel_r + 3'd1;
    end else begin
      arb_start_s = ptr_r;
    end
    pick_s = rr_pick(bus.req, arb_start_s);
  end

  // Controller FSM with registered sel/grant/valid and burst bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      sel_r   <= 3'd0;
      grant_r <= 8'd0;
      ptr_r   <= 3'd0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_s[3]) begin
            sel_r   <= pick_s[2:0];
            grant_r <= 8'd1 << pick_s[2:0];
            cnt_r   <= '0;
            valid_r <= 1'b1;
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // valid is always high here, so out_ready alone marks a transfer.
          if (bus.out_ready) begin
            if (bus.req[sel_r] && (cnt_r != LAST_CNT)) begin
              cnt_r <= cnt_r + CNT_ONE;
            end else begin
              ptr_r <= sel_r + 3'd1;
              cnt_r <= '0;
              if (pick_s[3]) begin
                sel_r   <= pick_s[2:0];
                grant_r <= 8'd1 << pick_s[2:0];
              end else begin
                // sel deliberately keeps its last value when going idle.
                valid_r <= 1'b0;
                grant_r <= 8'd0;
                state_r <= ST_IDLE;
              end
            end
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          grant_r <= 8'd0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.sel       = sel_r;
  assign bus.grant     = grant_r;
  // Only unregistered output: decode of the burst counter while valid.
  assign bus.out_last  = valid_r & (cnt_r == LAST_CNT);

endmodule

// File: tb/tb_mux8_rr_sel.sv
// Self-checking bench for mux8_rr_sel: directed scenarios followed by random
// traffic. Expected transfers are pushed into a queue by the stimulus side and
// popped by an independent monitor whenever the DUT performs a transfer.
module tb_mux8_rr_sel;
  localparam int MB = 4;

  logic clk;
  logic rst;
  mux8_rr_sel_if bus ();

  mux8_rr_sel #(.MAX_BURST(MB), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int sel;
    bit last;
  } xfer_t;
  xfer_t exp_q[$];

  // Reference model: who holds the grant and how far into the burst it is.
  bit m_active;
  int m_chan;
  int m_done;   // transfers already completed in the current burst
  int m_start;  // channel where the next search begins

  logic [7:0] req_v;
  logic       rdy_v;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_chan   = 0;
    m_done   = 0;
    m_start  = 0;
  endtask

  // What the spec says happens at one clock edge given the sampled inputs.
  task automatic model_edge(input logic [7:0] r, input logic rdy);
    if (!m_active) begin
      if (r != 8'd0) begin
        m_chan   = search(r, m_start);
        m_done   = 0;
        m_active = 1'b1;
      end
    end else if (rdy) begin
      if (r[m_chan] && (m_done + 1 < MB)) begin
        m_done++;
      end else begin
        m_start = (m_chan + 1) % 8;
        m_done  = 0;
        if (r != 8'd0) m_chan = search(r, m_start);
        else m_active = 1'b0;
      end
    end
  endtask

  // One cycle: advance the model at the edge, then drive new inputs and
  // record the transfer the DUT is expected to make at the following edge.
  task automatic step(input logic [7:0] r, input logic rdy);
    xfer_t x;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(req_v, rdy_v);
    #1;
    req_v = r;
    rdy_v = rdy;
    bus.req = r;
    bus.out_ready = rdy;
    if (m_active && rdy && !rst) begin
      x.sel  = m_chan;
      x.last = (m_done == MB - 1);
      exp_q.push_back(x);
    end
  endtask

  // Monitor: pop and compare on every DUT transfer; also check grant decode.
  always @(negedge clk) begin
    xfer_t e;
    if (!rst) begin
      check("grant_decode", int'(bus.grant),
            bus.out_valid ? (1 << bus.sel) : 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("xfer_sel", int'(bus.sel), e.sel);
          check("xfer_last", int'(bus.out_last), int'(e.last));
        end
      end
    end
  end

  initial begin
    logic [7:0] rr;
    model_reset();
    rst = 1'b1;
    req_v = 8'hFF;
    rdy_v = 1'b1;
    bus.req = 8'hFF;
    bus.out_ready = 1'b1;

    // 1: reset holds outputs quiet even with all requests up.
    for (int i = 0; i < 3; i++) begin
      step(8'hFF, 1'b1);
      check("rst_valid", int'(bus.out_valid), 0);
      check("rst_grant", int'(bus.grant), 0);
      check("rst_sel", int'(bus.sel), 0);
    end
    step(8'h00, 1'b0);
    rst = 1'b0;

    // 2: single requester; latency of one edge, repeated bursts of 4.
    step(8'h10, 1'b1);
    check("lat_before", int'(bus.out_valid), 0);
    step(8'h10, 1'b1);
    check("lat_valid", int'(bus.out_valid), 1);
    check("lat_sel", int'(bus.sel), 4);
    check("lat_grant", int'(bus.grant), 16);
    for (int i = 0; i < 8; i++) step(8'h10, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    check("idle_after_single", int'(bus.out_valid), 0);

    // 3: rotation between channels 0 and 7 (ptr is 5 here, so 7 comes first).
    for (int i = 0; i < 14; i++) step(8'h81, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // 4: backpressure with req[2] withdrawn while waiting.
    step(8'h04, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b0);
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_sel", int'(bus.sel), 2);
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    check("bp_idle", int'(bus.out_valid), 0);
    check("bp_sel_kept", int'(bus.sel), 2);

    // 5: early release (ptr=3, so channel 1 wins first, then 2 with no bubble).
    step(8'h06, 1'b0);
    step(8'h06, 1'b1);
    check("early_sel1", int'(bus.sel), 1);
    step(8'h04, 1'b1);
    step(8'h04, 1'b0);
    check("early_sel2", int'(bus.sel), 2);
    check("early_valid", int'(bus.out_valid), 1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // 6: async reset mid-burst on channel 5.
    step(8'h20, 1'b1);
    step(8'h20, 1'b1);
    step(8'h21, 1'b0);
    check("pre_rst_sel", int'(bus.sel), 5);
    #2 rst = 1'b1;
    #1;
    check("async_valid", int'(bus.out_valid), 0);
    check("async_grant", int'(bus.grant), 0);
    model_reset();
    rst = 1'b0;
    step(8'h21, 1'b1);
    check("post_rst_sel", int'(bus.sel), 0);

    // Random traffic.
    rr = 8'h21;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rr = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      end
      step(rr, ($urandom_range(0, 3) != 0));
    end

    // Drain and confirm every predicted transfer was seen.
    for (int i = 0; i < 6; i++) step(8'h00, 1'b1);
    check("drain_idle", int'(bus.out_valid), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
